// File: rtl/lc3b_rf_pkg.sv
// Shared constants and packed-bus index helpers for the LC-3b register file.
package lc3b_rf_pkg;

    localparam int LC3B_DATA_W   = 16;
    localparam int LC3B_NUM_REGS = 8;

    // Returns the LSB of field idx in a packed bus made of w-bit fields.
    function automatic int fld_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: a busy bit per register, set by claims and
// cleared by writes, plus a combinational RAW-hazard flag per read port.
module regfile_scoreboard
    import lc3b_rf_pkg::*;
#(
    parameter int NUM_REGS = LC3B_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [NUM_REGS-1:0]        busy_vec
);

    // Busy bits: a claim is a newer producer, so it beats a same-cycle write.
    // Out-of-range indices never match any r and are dropped naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ZERO_REG && r == 0)
                    busy_vec[r] <= 1'b0;
                else if (claim_en && claim_addr == ADDR_W'(r))
                    busy_vec[r] <= 1'b1;
                else if (wr_en && wr_addr == ADDR_W'(r))
                    busy_vec[r] <= 1'b0;
            end
        end
    end

    // Hazard per port: target busy and not being resolved by an in-flight write.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[fld_lsb(i, ADDR_W) +: ADDR_W] == ADDR_W'(r) && busy_vec[r] &&
                    !(wr_en && wr_addr == ADDR_W'(r)))
                    rd_busy[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-read-port register file with 1-cycle registered reads, write-to-read
// bypass, optional hardwired-zero R0 and a pending-write scoreboard.
module regfile_mp_bypass
    import lc3b_rf_pkg::*;
#(
    parameter int DATA_W   = LC3B_DATA_W,
    parameter int NUM_REGS = LC3B_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [NUM_REGS-1:0]        busy_vec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_next;

    // Storage array; R0 stays 0 when hardwired, out-of-range writes match nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_en && wr_addr == ADDR_W'(r) && !(ZERO_REG && r == 0))
                    regs[r] <= wr_data;
            end
        end
    end

    // Per-port read mux with bypass; zero R0 and out-of-range fall to the 0 default.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[fld_lsb(i, ADDR_W) +: ADDR_W] == ADDR_W'(r) && !(ZERO_REG && r == 0))
                    rd_next[i] = (wr_en && wr_addr == ADDR_W'(r)) ? wr_data : regs[r];
            end
        end
    end

    // Read output registers: load on request, hold otherwise; valid tracks rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i])
                    rd_data[fld_lsb(i, DATA_W) +: DATA_W] <= rd_next[i];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Bench for regfile_mp_bypass: directed tests on the default build (A) and
// directed plus randomized model checks on a 32-bit, 4-port, 6-register,
// zero-R0 build (B). Read expectations go through a scoreboard queue.
module tb_regfile_mp_bypass;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Build A: defaults (16-bit, 8 regs, 2 ports, no zero reg)
    logic        a_wr_en;
    logic [2:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic [1:0]  a_rd_en;
    logic [5:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_valid;
    logic        a_claim_en;
    logic [2:0]  a_claim_addr;
    logic [1:0]  a_rd_busy;
    logic [7:0]  a_busy_vec;

    // Build B: 32-bit, 6 regs (indices 6,7 out of range), 4 ports, zero R0
    logic         b_wr_en;
    logic [2:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic [3:0]   b_rd_en;
    logic [11:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_valid;
    logic         b_claim_en;
    logic [2:0]   b_claim_addr;
    logic [3:0]   b_rd_busy;
    logic [5:0]   b_busy_vec;

    regfile_mp_bypass dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .claim_en(a_claim_en), .claim_addr(a_claim_addr),
        .rd_busy(a_rd_busy), .busy_vec(a_busy_vec)
    );

    regfile_mp_bypass #(.DATA_W(32), .NUM_REGS(6), .NUM_RD(4), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .claim_en(b_claim_en), .claim_addr(b_claim_addr),
        .rd_busy(b_rd_busy), .busy_vec(b_busy_vec)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rd_en = '0; a_rd_addr = '0;
        a_claim_en = 1'b0; a_claim_addr = '0;
    endtask

    task automatic b_idle;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rd_en = '0; b_rd_addr = '0;
        b_claim_en = 1'b0; b_claim_addr = '0;
    endtask

    task automatic a_read(input int port, input logic [2:0] addr, input logic [15:0] exp);
        a_rd_en[port] = 1'b1;
        a_rd_addr[port*3 +: 3] = addr;
        exp_q.push_back('{port: port, data: {16'h0, exp}});
    endtask

    task automatic b_read(input int port, input logic [2:0] addr, input logic [31:0] exp);
        b_rd_en[port] = 1'b1;
        b_rd_addr[port*3 +: 3] = addr;
        exp_q.push_back('{port: port, data: exp});
    endtask

    task automatic a_drain(input string tag);
        rd_exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, a_rd_data[e.port*16 +: 16], e.data);
            chk({tag, "_valid"}, a_rd_valid[e.port], 1'b1);
        end
    endtask

    task automatic b_drain(input string tag);
        rd_exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, b_rd_data[e.port*32 +: 32], e.data);
            chk({tag, "_valid"}, b_rd_valid[e.port], 1'b1);
        end
    endtask

    // Reference model state for build B
    logic [31:0] m_reg  [6];
    logic        m_busy [6];
    logic [31:0] m_hold [4];

    initial begin
        logic [2:0]  ra;
        logic [3:0]  en_q;
        logic        rst_q;
        logic        eb;
        logic [31:0] ed;
        logic [5:0]  mb;
        rd_exp_t     e;

        a_idle();
        b_idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_a_busy", a_busy_vec, 8'h00);
        chk("rst_a_valid", a_rd_valid, 2'b00);
        chk("rst_a_data", a_rd_data, 32'h0);
        chk("rst_b_data", b_rd_data, 128'h0);
        chk("rst_b_busy", b_busy_vec, 6'h00);
        rst = 1'b0;

        // Reset wipes a committed value and overrides same-cycle write/claim/read
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h1234;
        tick();
        a_idle();
        rst = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'hFFFF;
        a_claim_en = 1'b1; a_claim_addr = 3'd3;
        a_rd_en = 2'b01; a_rd_addr = 6'd3;
        tick();
        rst = 1'b0;
        a_idle();
        chk("rst_over_valid", a_rd_valid, 2'b00);
        chk("rst_over_busy", a_busy_vec, 8'h00);
        a_read(0, 3'd3, 16'h0000);
        tick();
        a_drain("rst_r3");
        chk("rst_r3_busy", a_busy_vec, 8'h00);

        // Bypass: both ports read R5 in the cycle it is written
        a_idle();
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'hBEEF;
        a_read(1, 3'd5, 16'hBEEF);
        a_read(0, 3'd5, 16'hBEEF);
        tick();
        a_drain("bypass");

        // Hold: data stays while rd_en is low, even as the register changes
        a_idle();
        a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 16'h00AA;
        tick();
        a_idle();
        a_read(0, 3'd2, 16'h00AA);
        tick();
        a_drain("hold_rd");
        for (int k = 0; k < 3; k++) begin
            a_idle();
            a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 16'h5555;
            tick();
            chk("hold_data0", a_rd_data[15:0], 16'h00AA);
            chk("hold_valid0", a_rd_valid[0], 1'b0);
            chk("hold_data1", a_rd_data[31:16], 16'hBEEF);
        end
        a_idle();
        a_read(0, 3'd2, 16'h5555);
        tick();
        a_drain("hold_after");

        // Scoreboard: claim, hazard flag, write resolves, claim beats write
        a_idle();
        a_claim_en = 1'b1; a_claim_addr = 3'd4;
        tick();
        a_idle();
        chk("sb_claim_busy", a_busy_vec, 8'h10);
        a_rd_addr = {3'd4, 3'd1};
        #1;
        chk("sb_rd_busy", a_rd_busy, 2'b10);
        a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 16'h4444;
        #1;
        chk("sb_wr_resolves", a_rd_busy, 2'b00);
        tick();
        a_idle();
        chk("sb_cleared", a_busy_vec, 8'h00);
        a_claim_en = 1'b1; a_claim_addr = 3'd4;
        tick();
        a_claim_en = 1'b1; a_claim_addr = 3'd4;
        a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 16'h7777;
        tick();
        a_idle();
        chk("sb_claim_wins", a_busy_vec, 8'h10);
        a_claim_en = 1'b1; a_claim_addr = 3'd1;
        a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 16'h7777;
        tick();
        a_idle();
        chk("sb_mixed", a_busy_vec, 8'h02);
        a_wr_en = 1'b1; a_wr_addr = 3'd6; a_wr_data = 16'h0606;
        a_read(0, 3'd4, 16'h7777);
        tick();
        a_idle();
        a_drain("sb_r4");
        chk("sb_nonbusy_wr", a_busy_vec, 8'h02);

        // Build B: hardwired R0 and out-of-range indices
        b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 32'hFFFF_FFFF;
        b_claim_en = 1'b1; b_claim_addr = 3'd0;
        tick();
        b_idle();
        chk("z_busy0", b_busy_vec, 6'h00);
        b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 32'hFFFF_FFFF;
        for (int p = 0; p < 3; p++) b_read(p, 3'd0, 32'h0);
        b_read(3, 3'd7, 32'h0);
        tick();
        b_drain("z_r0");
        b_idle();

        // Build B randomized against the reference model
        for (int r = 0; r < 6; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
        for (int p = 0; p < 4; p++) m_hold[p] = (p < 3) ? 32'h0 : 32'h0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rst          = ($urandom_range(0, 99) == 0);
            b_wr_en      = 1'($urandom_range(0, 1));
            b_wr_addr    = 3'($urandom_range(0, 7));
            b_wr_data    = $urandom;
            b_claim_en   = ($urandom_range(0, 3) == 0);
            b_claim_addr = 3'($urandom_range(0, 7));
            b_rd_en      = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) b_rd_addr[p*3 +: 3] = 3'($urandom_range(0, 7));
            #1;
            en_q  = b_rd_en;
            rst_q = rst;
            for (int p = 0; p < 4; p++) begin
                ra = b_rd_addr[p*3 +: 3];
                eb = (ra < 3'd6) && m_busy[ra] && !(b_wr_en && b_wr_addr == ra);
                chk("rnd_rd_busy", b_rd_busy[p], eb);
                if (!rst_q && en_q[p]) begin
                    if (ra == 3'd0 || ra >= 3'd6) ed = 32'h0;
                    else if (b_wr_en && b_wr_addr == ra) ed = b_wr_data;
                    else ed = m_reg[ra];
                    exp_q.push_back('{port: p, data: ed});
                end
            end
            if (rst_q) begin
                for (int r = 0; r < 6; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
                for (int p = 0; p < 4; p++) m_hold[p] = '0;
            end else begin
                if (b_wr_en && b_wr_addr != 3'd0 && b_wr_addr < 3'd6) m_reg[b_wr_addr] = b_wr_data;
                for (int r = 1; r < 6; r++) begin
                    if (b_claim_en && b_claim_addr == 3'(r)) m_busy[r] = 1'b1;
                    else if (b_wr_en && b_wr_addr == 3'(r)) m_busy[r] = 1'b0;
                end
            end
            tick();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rnd_rd_data", b_rd_data[e.port*32 +: 32], e.data);
                m_hold[e.port] = e.data;
            end
            for (int p = 0; p < 4; p++) begin
                chk("rnd_rd_valid", b_rd_valid[p], !rst_q && en_q[p]);
                if (rst_q || !en_q[p]) chk("rnd_rd_hold", b_rd_data[p*32 +: 32], m_hold[p]);
            end
            for (int r = 0; r < 6; r++) mb[r] = m_busy[r];
            chk("rnd_busy_vec", b_busy_vec, mb);
        end
        rst = 1'b0;
        b_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
- Parametrised multi-read-port register file for the LC-3b datapath and its pipelined successors.
- Registered (1-cycle) reads with write-to-read bypass.
- Per-register pending-write scoreboard so decode can detect RAW hazards and stall.
- Optional hardwired-zero register for RISC-style variants.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of architectural registers (>=2).
- ADDR_W, $clog2(NUM_REGS), register index width.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 0, 1 = register 0 reads as 0, and writes/claims to it are ignored.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  write data (from ALU/memory).
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  packed read indices, port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_valid  out  NUM_RD  rd_data[i] updated this cycle by a request issued the previous cycle.
- claim_en  in  1  mark wr_addr-independent destination as pending.
- claim_addr  in  ADDR_W  register to mark busy.
- rd_busy  out  NUM_RD  combinational hazard flag per read port.
- busy_vec  out  NUM_REGS  scoreboard state.

Behaviour:
- Reset (rst=1 at edge): all registers <= 0, rd_data <= 0, rd_valid <= 0, busy_vec <= 0. Reset overrides every same-cycle write, claim or read.
- Write: wr_en=1 at edge N commits R[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency is 1 cycle. With rd_en[i]=1 at edge N, from N on:
  - rd_data[i] = R[rd_addr[i]] as it stands after this edge (write-first).
  - A same-cycle write to the same index is bypassed: rd_data[i] = wr_data.
  - rd_valid[i] = 1.
- With rd_en[i]=0: rd_data[i] holds its previous value and rd_valid[i] <= 0.
- Ports are fully independent. Any number of ports may read the same index in the same cycle, and all get identical data.
- ZERO_REG=1 and rd_addr[i]=0: rd_data[i] = 0 regardless of bypass.
- Scoreboard, per register r, at each edge:
  - claim_en & claim_addr==r: busy[r] <= 1.
  - Else wr_en & wr_addr==r: busy[r] <= 0.
  - Claim and write to the same r in one cycle: claim wins, busy stays 1 (a newer producer has been issued).
- Claims to register 0 are ignored when ZERO_REG=1.
- A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i] = busy[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]). The in-flight write resolves the hazard via bypass. rd_busy is independent of rd_en.
- Out-of-range indices (NUM_REGS not a power of 2): writes and claims are dropped, reads return 0, rd_busy = 0.
- No X on any output after the first reset edge.

Decomposition:
- Shared package lc3b_rf_pkg holds:
  - LC3B_DATA_W=16, LC3B_NUM_REGS=8.
  - A function for pack/unpack index arithmetic of the packed port buses.
- One natural sub-module: regfile_scoreboard, containing the busy_vec register, claim/clear priority and rd_busy generation, parametrised by NUM_REGS and NUM_RD.
- The storage array and read/bypass muxes stay in the top level.

Test Plan:
- Reset: write R3=0x1234, assert rst one cycle, read R3 on port0 -> rd_data[0]=0x0000, rd_valid=1 the cycle after the request, busy_vec=0.
- Bypass: same cycle wr_en R5<=0xBEEF and rd_en[1] on R5 -> next cycle rd_data[1]=0xBEEF. Port0 reading R5 in the same cycle also returns 0xBEEF.
- Hold: read R2=0x00AA, then drop rd_en[0] for 3 cycles while writing R2<=0x5555 -> rd_data[0] stays 0x00AA and rd_valid[0]=0.
- Scoreboard: claim R4 -> busy_vec=0x10, rd_busy=1 for a port addressing R4.
  - Cycle with wr_en R4 -> rd_busy=0 that cycle, busy clears next edge.
  - Simultaneous claim R4 and write R4 -> busy stays 1.
- ZERO_REG=1 build: write R0<=0xFFFF and claim R0 -> read R0 gives 0x0000, busy_vec[0]=0.
- NUM_RD=4, DATA_W=32 build: random writes vs. a reference model over 1000 cycles -> all four ports match every cycle.
